uart_matrix_loader: RTL and testbench
=====================================

Name: uart_matrix_loader

Overview:
- Receives the two 3x3 operand matrices (A, then B) as 18 unsigned bytes over a UART 8N1 serial line.
- Presents them as flat buses to the serial matrix multiplier, replacing constant operands on the board top.
- Outputs update atomically once a full 18-byte frame arrives, then a one-cycle load_done pulse fires so the multiplier can restart.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); minimum 8.
- TIMEOUT_BITS, 20, idle bit-times allowed between bytes of one frame before the partial frame is discarded.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- rx  in  1  UART serial input, idle high, asynchronous to clk
- mat_a  out  72  A elements; a0 at [7:0] through a8 at [71:64], row-major
- mat_b  out  72  B elements; b0 at [7:0] through b8 at [71:64]
- load_done  out  1  one-cycle pulse when mat_a/mat_b take a new frame
- busy  out  1  high while a partial frame is held (byte index != 0)
- frame_err  out  1  one-cycle pulse on stop-bit error or inter-byte timeout

Behaviour:
- Reset (rst low, async):
  - mat_a, mat_b, load_done, busy, frame_err = 0.
  - Byte index = 0; RX FSM = IDLE; rx synchronizer flops = 1.
- rx passes through a 2-flop synchronizer; all logic uses the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronized 0 enters START with the bit counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, resample. If 1 (glitch), return to IDLE with no byte and no error. If 0, enter DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. If 1, raise byte_valid for one cycle. If 0, raise a framing error for one cycle. Return to IDLE either way; the line must be seen high before a new start is accepted.
- Loader:
  - An 18-entry byte staging buffer with index 0..17. On byte_valid, write buffer[index] and increment index.
  - On the byte that writes index 17: copy the buffer to mat_a (0..8) and mat_b (9..17) and clear index. mat_a, mat_b and load_done change on the clock edge after that byte_valid.
  - Latency from the stop-bit sample to load_done high is 1 clk.
- Output stability: mat_a/mat_b never show a partial frame. Previous values hold until the next complete frame.
- Framing error: the received byte is dropped, index clears to 0, frame_err pulses, and outputs are unchanged.
- Timeout: when index != 0, a counter counts clk cycles while the RX FSM is in IDLE. It reaches TIMEOUT_BITS*CLKS_PER_BIT, then index clears to 0 and frame_err pulses. The counter clears on every start detect. With index == 0 the counter is held at 0.
- Simultaneous timeout and start detect in the same cycle: the start wins, with no timeout and no error.
- busy = (index != 0), registered.
- Reset mid-byte or mid-frame: all state is discarded immediately. Reception resumes from the next falling edge after rst is released.
- Bytes are unsigned and carry no escape or sync character. Resync relies on the timeout.

Decomposition:
- Shared package: MAT_ELEMS = 9, FRAME_BYTES = 18, ELEM_W = 8, and the RX state encoding.
- One sub-module, uart_rx: synchronizer, RX FSM and bit timing. Its outputs are data[7:0], byte_valid and stop_err.
- uart_matrix_loader holds the index, staging buffer, timeout counter and output registers.

Test Plan:
- Bench uses CLKS_PER_BIT = 16.
- Normal frame: send bytes 1..9 then 9..1 with 1 stop bit between bytes -> exactly one load_done, 1 clk after the final stop sample. mat_a = {9,8,...,1} (a0 = 1), mat_b with b0 = 9 and b8 = 1. busy high from byte 1 until load_done.
- Back-to-back frames: send frame 1, then a frame of all 0xFF -> two load_done pulses. mat_a/mat_b = all 0xFF after the second. Between frames, outputs hold frame 1 values with no partial update.
- Framing error: send 5 good bytes, then 0x55 with stop bit 0 -> frame_err pulses once, busy drops, and outputs still hold the prior frame. Then send 18 fresh bytes -> a correct load.
- Timeout: send 7 bytes, then idle 21 bit-times -> frame_err pulses and busy drops. Then send a full frame -> it loads with a0 equal to the first new byte.
- Glitch: a 3-clk low pulse on rx -> no byte, no error, index unchanged.
- Async reset: assert rst low at byte 10, mid-data-bit -> all outputs 0 immediately. After release, a full frame loads correctly.

Source files
------------

// File: rtl/uart_matrix_loader_pkg.sv
// Shared sizes and receiver state encoding for the UART matrix loader.
package uart_matrix_loader_pkg;

   localparam int MAT_ELEMS   = 9;
   localparam int FRAME_BYTES = 18;
   localparam int ELEM_W      = 8;
   localparam int IDX_W       = $clog2(FRAME_BYTES);

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_matrix_loader_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle
// byte_valid / stop_err pulses. The FSM state is exported for the loader's
// timeout logic and for debug.
module uart_rx
   import uart_matrix_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_i,
   output logic [ELEM_W-1:0] data_o,
   output logic              byte_valid_o,
   output logic              stop_err_o,
   output logic              start_o,
   output rx_state_e         state_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);

   rx_state_e         state_q;
   logic              rx_meta_q;
   logic              rx_sync_q;
   logic              armed_q;     // line has been seen high since the last stop bit
   logic [CW-1:0]     cnt_q;
   logic [2:0]        bit_idx_q;
   logic [ELEM_W-1:0] shift_q;
   logic [ELEM_W-1:0] data_q;
   logic              byte_valid_q;
   logic              stop_err_q;

   // A start is a synchronized low seen in IDLE after the line was high.
   assign start_o      = (state_q == RX_IDLE) && armed_q && !rx_sync_q;
   assign data_o       = data_q;
   assign byte_valid_o = byte_valid_q;
   assign stop_err_o   = stop_err_q;
   assign state_o      = state_q;

   // Synchronizer, bit timing and the receive FSM with registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= RX_IDLE;
         rx_meta_q    <= 1'b1;
         rx_sync_q    <= 1'b1;
         armed_q      <= 1'b0;
         cnt_q        <= '0;
         bit_idx_q    <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         byte_valid_q <= 1'b0;
         stop_err_q   <= 1'b0;
      end else begin
         rx_meta_q    <= rx_i;
         rx_sync_q    <= rx_meta_q;
         byte_valid_q <= 1'b0;
         stop_err_q   <= 1'b0;
         case (state_q)
            RX_IDLE: begin
               if (rx_sync_q) armed_q <= 1'b1;
               if (start_o) begin
                  state_q <= RX_START;
                  cnt_q   <= '0;
               end
            end
            RX_START: begin
               if (cnt_q == HALF_END) begin
                  cnt_q     <= '0;
                  bit_idx_q <= '0;
                  // A high line at mid start bit is a glitch: drop silently.
                  state_q   <= rx_sync_q ? RX_IDLE : RX_DATA;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_DATA: begin
               if (cnt_q == BIT_END) begin
                  cnt_q     <= '0;
                  shift_q   <= {rx_sync_q, shift_q[ELEM_W-1:1]};
                  bit_idx_q <= bit_idx_q + 1'b1;
                  if (bit_idx_q == 3'd7) state_q <= RX_STOP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RX_STOP: begin
               if (cnt_q == BIT_END) begin
                  cnt_q   <= '0;
                  state_q <= RX_IDLE;
                  armed_q <= rx_sync_q;
                  if (rx_sync_q) begin
                     data_q       <= shift_q;
                     byte_valid_q <= 1'b1;
                  end else begin
                     stop_err_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= RX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_matrix_loader.sv
// Collects 18 UART bytes into a staging buffer and publishes them atomically
// as the A and B operand matrices, with framing-error and timeout recovery.
module uart_matrix_loader
   import uart_matrix_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868,
   parameter int TIMEOUT_BITS = 20
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        rx,
   output logic [MAT_ELEMS*ELEM_W-1:0] mat_a,
   output logic [MAT_ELEMS*ELEM_W-1:0] mat_b,
   output logic                        load_done,
   output logic                        busy,
   output logic                        frame_err
);

   localparam int MAT_W     = MAT_ELEMS * ELEM_W;
   localparam int FRAME_W   = FRAME_BYTES * ELEM_W;
   localparam int TMO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW        = $clog2(TMO_LIMIT + 1);
   localparam logic [TW-1:0]    TMO_END  = TW'(TMO_LIMIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

   logic [ELEM_W-1:0] rx_data;
   logic              rx_valid;
   logic              rx_stop_err;
   logic              rx_start;
   rx_state_e         rx_state;

   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [TW-1:0]      tmo_q, tmo_d;
   logic [FRAME_W-1:0] buf_q;
   logic [FRAME_W-1:0] frame_w;
   logic [7:0]         wr_base;
   logic [MAT_W-1:0]   mat_a_q, mat_b_q;
   logic               load_d, load_done_q;
   logic               err_d, frame_err_q;
   logic               busy_q;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk          (clk),
      .rst          (rst),
      .rx_i         (rx),
      .data_o       (rx_data),
      .byte_valid_o (rx_valid),
      .stop_err_o   (rx_stop_err),
      .start_o      (rx_start),
      .state_o      (rx_state)
   );

   // The last byte bypasses the buffer so the whole frame lands in one edge.
   assign frame_w = {rx_data, buf_q[FRAME_W-ELEM_W-1:0]};
   assign wr_base = {idx_q, 3'b000};

   assign mat_a     = mat_a_q;
   assign mat_b     = mat_b_q;
   assign load_done = load_done_q;
   assign busy      = busy_q;
   assign frame_err = frame_err_q;

   // Next index, inter-byte timeout and the load / error pulses.
   always_comb begin
      idx_d  = idx_q;
      tmo_d  = tmo_q;
      load_d = 1'b0;
      err_d  = 1'b0;
      if (rx_stop_err) begin
         idx_d = '0;
         err_d = 1'b1;
      end else if (rx_valid) begin
         if (idx_q == LAST_IDX) begin
            idx_d  = '0;
            load_d = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end
      // A start detect always beats an expiring timeout.
      if (idx_q == '0 || rx_start) begin
         tmo_d = '0;
      end else if (rx_state == RX_IDLE && !rx_valid && !rx_stop_err) begin
         if (tmo_q == TMO_END) begin
            tmo_d = '0;
            idx_d = '0;
            err_d = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
   end

   // Staging buffer, output matrices and status registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q       <= '0;
         tmo_q       <= '0;
         buf_q       <= '0;
         mat_a_q     <= '0;
         mat_b_q     <= '0;
         load_done_q <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         idx_q       <= idx_d;
         tmo_q       <= tmo_d;
         load_done_q <= load_d;
         frame_err_q <= err_d;
         busy_q      <= (idx_d != '0);
         if (rx_valid && !rx_stop_err) buf_q[wr_base +: ELEM_W] <= rx_data;
         if (load_d) begin
            mat_a_q <= frame_w[MAT_W-1:0];
            mat_b_q <= frame_w[FRAME_W-1:MAT_W];
         end
      end
   end

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Bench for uart_matrix_loader: serial driver, byte-level frame model,
// expected-frame scoreboard and end-of-run report.
module tb_uart_matrix_loader;

   localparam int CPB   = 16;
   localparam int TBITS = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx;
   logic [71:0] mat_a, mat_b;
   logic        load_done, busy, frame_err;

   uart_matrix_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TBITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .mat_a     (mat_a),
      .mat_b     (mat_b),
      .load_done (load_done),
      .busy      (busy),
      .frame_err (frame_err)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- scoreboard state ----------------
   int tests = 0, fails = 0;
   int load_cnt = 0, err_cnt = 0, exp_loads = 0, exp_errs = 0;
   int stab_viol = 0, load_cyc = 0, stop_cyc = 0;
   logic [143:0] exp_q[$];
   logic [143:0] cur_exp = '0;
   logic [7:0]   pend[$];

   task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: bytes accumulate; every 18th completes a frame with
   // byte i placed at element i (a0..a8 then b0..b8).
   function automatic void model_byte(input logic [7:0] b);
      logic [143:0] f;
      pend.push_back(b);
      if (pend.size() == 18) begin
         f = '0;
         for (int i = 0; i < 18; i++) f[i*8 +: 8] = pend[i];
         exp_q.push_back(f);
         exp_loads++;
         pend.delete();
      end
   endfunction

   function automatic void model_drop();
      pend.delete();
   endfunction

   // Monitor: every load pulse must deliver the next expected frame; between
   // loads the outputs must hold the last delivered frame.
   always @(negedge clk) begin
      if (rst) begin
         if (load_done) begin
            load_cnt++;
            load_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("load_pending", 144'(exp_q.size()), 144'd1);
            end else begin
               cur_exp = exp_q.pop_front();
               check("frame", {mat_b, mat_a}, cur_exp);
            end
         end else if ({mat_b, mat_a} !== cur_exp) begin
            stab_viol++;
         end
         if (frame_err) err_cnt++;
      end
   end

   // ---------------- driver tasks (enter and leave on a negedge) ----------------
   task automatic idle_bits(input int n);
      rx = 1'b1;
      repeat (n * CPB) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stop_bit;
      stop_cyc = cyc;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] fr[18], input int max_gap, input int glitch_after);
      int l0;
      l0 = load_cnt;
      for (int i = 0; i < 18; i++) begin
         model_byte(fr[i]);
         send_byte(fr[i], 1'b1);
         if (i == 0) check("busy_first_byte", 144'(busy), 144'd1);
         if (i == glitch_after) begin
            rx = 1'b0;
            repeat (3) @(negedge clk);
            idle_bits(2);
            check("glitch_busy", 144'(busy), 144'd1);
            check("glitch_no_err", 144'(err_cnt), 144'(exp_errs));
         end
         if (i < 17 && max_gap > 0) idle_bits($urandom_range(0, max_gap));
      end
      check("one_load", 144'(load_cnt - l0), 144'd1);
      check("load_in_stop_bit",
            144'((load_cyc - stop_cyc) >= CPB / 2 && (load_cyc - stop_cyc) <= CPB), 144'd1);
      check("busy_after_load", 144'(busy), 144'd0);
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] fr[18];

   initial begin
      rx  = 1'b1;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_mat_a", 144'(mat_a), 144'd0);
      check("reset_mat_b", 144'(mat_b), 144'd0);
      check("reset_flags", 144'({load_done, busy, frame_err}), 144'd0);
      rst = 1'b1;
      idle_bits(2);

      // Normal frame: 1..9 then 9..1
      for (int i = 0; i < 18; i++) fr[i] = (i < 9) ? 8'(i + 1) : 8'(18 - i);
      send_frame(fr, 0, -1);
      check("normal_mat_a", 144'(mat_a), 144'(72'h090807060504030201));
      check("normal_mat_b", 144'(mat_b), 144'(72'h010203040506070809));

      // Back-to-back: frame 1 again, then all 0xFF
      send_frame(fr, 0, -1);
      for (int i = 0; i < 18; i++) fr[i] = 8'hFF;
      send_frame(fr, 0, -1);
      check("ff_mats", {mat_b, mat_a}, {144{1'b1}});

      // Random frames with random inter-byte gaps below the timeout
      for (int f = 0; f < 3; f++) begin
         for (int i = 0; i < 18; i++) fr[i] = 8'($urandom_range(0, 255));
         send_frame(fr, 3, -1);
      end

      // Framing error after 5 good bytes
      for (int i = 0; i < 5; i++) begin
         fr[i] = 8'($urandom_range(0, 255));
         model_byte(fr[i]);
         send_byte(fr[i], 1'b1);
      end
      model_drop();
      send_byte(8'h55, 1'b0);
      exp_errs++;
      idle_bits(1);
      check("ferr_count", 144'(err_cnt), 144'(exp_errs));
      check("ferr_busy", 144'(busy), 144'd0);
      check("ferr_hold", {mat_b, mat_a}, cur_exp);
      for (int i = 0; i < 18; i++) fr[i] = 8'($urandom_range(0, 255));
      send_frame(fr, 1, -1);

      // Timeout: 7 bytes, then idle past TIMEOUT_BITS bit-times
      for (int i = 0; i < 7; i++) begin
         fr[i] = 8'($urandom_range(0, 255));
         model_byte(fr[i]);
         send_byte(fr[i], 1'b1);
      end
      idle_bits(TBITS - 1);
      check("tmo_not_yet", 144'(err_cnt), 144'(exp_errs));
      check("tmo_busy_held", 144'(busy), 144'd1);
      idle_bits(2);
      model_drop();
      exp_errs++;
      check("tmo_err", 144'(err_cnt), 144'(exp_errs));
      check("tmo_busy", 144'(busy), 144'd0);
      for (int i = 0; i < 18; i++) fr[i] = 8'($urandom_range(0, 255));
      send_frame(fr, 0, -1);
      check("tmo_a0", 144'(mat_a[7:0]), 144'(fr[0]));

      // Glitch in the middle of a frame
      for (int i = 0; i < 18; i++) fr[i] = 8'($urandom_range(0, 255));
      send_frame(fr, 0, 3);

      // Async reset in the middle of byte 10
      for (int i = 0; i < 9; i++) begin
         fr[i] = 8'($urandom_range(0, 255));
         model_byte(fr[i]);
         send_byte(fr[i], 1'b1);
      end
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      repeat (CPB) @(negedge clk);
      rx = 1'b0;
      repeat (CPB / 2) @(negedge clk);
      #2;
      rst = 1'b0;
      model_drop();
      cur_exp = '0;
      #1;
      check("arst_mats", {mat_b, mat_a}, 144'd0);
      check("arst_flags", 144'({load_done, busy, frame_err}), 144'd0);
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      idle_bits(2);
      for (int i = 0; i < 18; i++) fr[i] = 8'($urandom_range(0, 255));
      send_frame(fr, 2, -1);
      idle_bits(2);

      // ---------------- final report ----------------
      check("load_count", 144'(load_cnt), 144'(exp_loads));
      check("err_count", 144'(err_cnt), 144'(exp_errs));
      check("output_stability", 144'(stab_viol), 144'd0);
      check("exp_q_drained", 144'(exp_q.size()), 144'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
